apu_dma_sched: RTL and testbench



---
 rtl/apu_dma_pkg.sv | 17 +
 rtl/apu_dma_busmux.sv | 39 +++
 rtl/apu_dma_sched.sv | 167 ++++++++++++++++
 tb/tb_apu_dma_sched.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apu_dma_pkg.sv
// Shared types and constants for the APU bus scheduler (sprite and DMC sample DMA).
package apu_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StDummy,
    StAlign,
    StOamRd,
    StOamWr,
    StDmcRd
  } dma_state_e;

  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;
  localparam int unsigned OAM_LEN      = 256;

endpackage

// File: rtl/apu_dma_busmux.sv
// Pad-side address/RW/data-enable selector, keyed by the scheduler state.
module apu_dma_busmux
  import apu_dma_pkg::*;
(
  input  dma_state_e  state_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rw_i,
  input  logic [7:0]  page_i,
  input  logic [7:0]  cnt_i,
  input  logic [15:0] dmc_addr_i,
  output logic [15:0] addr_o,
  output logic        rw_o,
  output logic        db_oe_o
);

  // The core keeps the bus in IDLE/HALT/DUMMY/ALIGN; DMA states own it.
  always_comb begin
    addr_o  = cpu_addr_i;
    rw_o    = cpu_rw_i;
    db_oe_o = 1'b0;
    unique case (state_i)
      StOamRd: begin
        addr_o = {page_i, cnt_i};
        rw_o   = 1'b1;
      end
      StOamWr: begin
        addr_o  = OAMDATA_ADDR;
        rw_o    = 1'b0;
        db_oe_o = 1'b1;
      end
      StDmcRd: begin
        addr_o = dmc_addr_i;
        rw_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/apu_dma_sched.sv
// APU external-bus cycle scheduler: core halt, $4014 sprite copy and DMC sample fetches.
// DMC fetch path is built only when APU_DMC_DMA_EN is defined.
module apu_dma_sched
  import apu_dma_pkg::*;
(
  input  logic        CLK,
  input  logic        n_RES,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        oam_start,
  input  logic [7:0]  oam_page,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  input  logic [7:0]  db_in,
  output logic [15:0] Addr_topad,
  output logic        RW_topad,
  output logic [7:0]  db_out,
  output logic        db_oe,
  output logic        RDY,
  output logic [7:0]  dmc_data,
  output logic        dmc_ack,
  output logic        dma_busy
);

  localparam logic [7:0] OamLast = 8'(OAM_LEN - 1);

  dma_state_e state_q;
  dma_state_e read_st;
  logic       put_q;
  logic       oam_pend_q;
  logic       rdy_q;
  logic [7:0] cnt_q;
  logic [7:0] page_q;
  logic [7:0] byte_q;
  logic       dmc_pend;
  logic       dmc_now;
  logic       oam_now;
  logic       next_get;

  assign next_get = put_q;
  assign oam_now  = oam_pend_q | oam_start;

`ifdef APU_DMC_DMA_EN
  logic       dmc_pend_q;
  logic       dmc_ack_q;
  logic [7:0] dmc_data_q;
  logic       dmc_take;

  // A level request is not re-armed by the fetch it has just been served with.
  assign dmc_take = dmc_req && (state_q != StDmcRd) && !dmc_ack_q;
  assign dmc_pend = dmc_pend_q;
  assign dmc_now  = dmc_pend_q | dmc_take;
  assign read_st  = dmc_now ? StDmcRd : StOamRd;
  assign dmc_ack  = dmc_ack_q;
  assign dmc_data = dmc_data_q;

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      dmc_pend_q <= 1'b0;
      dmc_ack_q  <= 1'b0;
      dmc_data_q <= 8'h00;
    end else begin
      dmc_ack_q <= (state_q == StDmcRd);
      if (state_q == StDmcRd) begin
        dmc_pend_q <= 1'b0;
        dmc_data_q <= db_in;
      end else if (dmc_take) begin
        dmc_pend_q <= 1'b1;
      end
    end
  end
`else
  logic unused_dmc_req;

  assign unused_dmc_req = dmc_req;
  assign dmc_pend       = 1'b0;
  assign dmc_now        = 1'b0;
  assign read_st        = StOamRd;
  assign dmc_ack        = 1'b0;
  assign dmc_data       = 8'h00;
`endif

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q    <= StIdle;
      put_q      <= 1'b0;
      cnt_q      <= 8'h00;
      page_q     <= 8'h00;
      byte_q     <= 8'h00;
      oam_pend_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      put_q <= ~put_q;
      if (oam_start && !oam_pend_q) begin
        oam_pend_q <= 1'b1;
        page_q     <= oam_page;
      end
      unique case (state_q)
        StIdle: begin
          if (oam_now || dmc_now) begin
            state_q <= StHalt;
            rdy_q   <= 1'b0;
          end
        end
        // Core writes run to completion; leave on its first (discarded) read.
        StHalt: begin
          if (cpu_rw) begin
            if (dmc_now && !oam_now) state_q <= StDummy;
            else if (next_get)       state_q <= read_st;
            else                     state_q <= StAlign;
          end
        end
`ifdef APU_DMC_DMA_EN
        StDummy: state_q <= next_get ? StDmcRd : StAlign;
        StDmcRd: begin
          if (oam_pend_q) begin
            state_q <= StAlign;
          end else begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
          end
        end
`endif
        StAlign: begin
          if (next_get) state_q <= read_st;
        end
        StOamRd: begin
          byte_q  <= db_in;
          state_q <= StOamWr;
        end
        StOamWr: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == OamLast) oam_pend_q <= 1'b0;
          if (dmc_now) begin
            state_q <= StDmcRd;
          end else if (oam_pend_q && cnt_q != OamLast) begin
            state_q <= StOamRd;
          end else begin
            state_q <= StIdle;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  apu_dma_busmux u_busmux (
    .state_i    (state_q),
    .cpu_addr_i (cpu_addr),
    .cpu_rw_i   (cpu_rw),
    .page_i     (page_q),
    .cnt_i      (cnt_q),
    .dmc_addr_i (dmc_addr),
    .addr_o     (Addr_topad),
    .rw_o       (RW_topad),
    .db_oe_o    (db_oe)
  );

  assign db_out   = byte_q;
  assign RDY      = rdy_q;
  assign dma_busy = oam_pend_q | dmc_pend | (state_q != StIdle);

endmodule

// File: tb/tb_apu_dma_sched.sv
// Bench for apu_dma_sched: per-cycle expected bus traces built from the transfer rules.
`timescale 1ns/1ps
module tb_apu_dma_sched;

  logic        CLK = 1'b0;
  logic        n_RES;
  logic [15:0] cpu_addr;
  logic        cpu_rw;
  logic        oam_start;
  logic [7:0]  oam_page;
  logic        dmc_req;
  logic [15:0] dmc_addr;
  logic [7:0]  db_in;
  logic [15:0] Addr_topad;
  logic        RW_topad;
  logic [7:0]  db_out;
  logic        db_oe;
  logic        RDY;
  logic [7:0]  dmc_data;
  logic        dmc_ack;
  logic        dma_busy;

  always #5 CLK = ~CLK;

`ifdef APU_DMC_DMA_EN
  localparam bit DmcEn = 1'b1;
`else
  localparam bit DmcEn = 1'b0;
`endif

  apu_dma_sched dut (
    .CLK        (CLK),
    .n_RES      (n_RES),
    .cpu_addr   (cpu_addr),
    .cpu_rw     (cpu_rw),
    .oam_start  (oam_start),
    .oam_page   (oam_page),
    .dmc_req    (dmc_req),
    .dmc_addr   (dmc_addr),
    .db_in      (db_in),
    .Addr_topad (Addr_topad),
    .RW_topad   (RW_topad),
    .db_out     (db_out),
    .db_oe      (db_oe),
    .RDY        (RDY),
    .dmc_data   (dmc_data),
    .dmc_ack    (dmc_ack),
    .dma_busy   (dma_busy)
  );

  // One record per CPU cycle: inputs to drive and pad/handshake values required.
  typedef struct {
    logic [15:0] ca;
    logic        crw;
    logic        os;
    logic [7:0]  pg;
    logic        dr;
    logic [15:0] da;
    logic [7:0]  din;
    logic [15:0] ea;
    logic        erw;
    logic        eoe;
    logic [7:0]  edo;
    logic        erdy;
    logic        eack;
    logic [7:0]  edat;
  } vec_t;

  vec_t        q[$];
  bit          g_put;
  bit          g_ack;
  logic [7:0]  g_ack_dat;
  logic [7:0]  g_dat;
  logic [7:0]  g_page;
  logic [15:0] g_daddr;
  string       g_name;
  int          total;
  int          bad;

  function automatic vec_t blank(logic os, logic dr, logic crw, logic rdy);
    vec_t v;
    v.ca   = 16'($urandom);
    v.crw  = crw;
    v.os   = os;
    v.pg   = g_page;
    v.dr   = dr;
    v.da   = g_daddr;
    v.din  = 8'($urandom);
    v.ea   = v.ca;
    v.erw  = crw;
    v.eoe  = 1'b0;
    v.edo  = 8'h00;
    v.erdy = rdy;
    v.eack = 1'b0;
    v.edat = 8'h00;
    return v;
  endfunction

  // Appends a cycle; the ack/data expectation follows from the previous fetch.
  function automatic void push(vec_t v);
    v.eack = g_ack;
    if (g_ack) g_dat = g_ack_dat;
    g_ack  = 1'b0;
    v.edat = g_dat;
    q.push_back(v);
    g_put = ~g_put;
  endfunction

  function automatic void gcpu(logic os, logic dr, logic crw, logic rdy);
    push(blank(os, dr, crw, rdy));
  endfunction

  function automatic void gdmc_rd(logic [7:0] din);
    vec_t v;
    v     = blank(1'b0, 1'b0, 1'b1, 1'b0);
    v.ea  = g_daddr;
    v.erw = 1'b1;
    v.din = din;
    push(v);
    g_ack     = 1'b1;
    g_ack_dat = din;
  endfunction

  // Sprite copy trace; returns the number of RDY-low cycles it implies.
  function automatic int gen_oam(int w, bit dmc_start, int dmc_at, int nbytes);
    bit   sp;
    bit   halt_get;
    bit   steal;
    vec_t v;
    vec_t vw;
    sp    = g_put;
    steal = DmcEn && (dmc_start || dmc_at >= 0);
    gcpu(1'b1, dmc_start, 1'b0, 1'b1);
    repeat (w) gcpu(1'b0, 1'b0, 1'b0, 1'b0);
    halt_get = (sp ^ 1'((w + 1) % 2)) == 1'b0;
    gcpu(1'b0, 1'b0, 1'b1, 1'b0);
    if (DmcEn && dmc_start) begin
      if (g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b0);
      gdmc_rd(8'($urandom));
    end
    for (int i = 0; i < nbytes; i++) begin
      if (g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b0);
      v     = blank(1'b0, i == dmc_at, 1'b1, 1'b0);
      v.ea  = {g_page, 8'(i)};
      v.erw = 1'b1;
      push(v);
      vw     = blank(1'b0, 1'b0, 1'b1, 1'b0);
      vw.ea  = 16'h2004;
      vw.erw = 1'b0;
      vw.eoe = 1'b1;
      vw.edo = v.din;
      push(vw);
      if (DmcEn && i == dmc_at) gdmc_rd(8'($urandom));
    end
    if (nbytes == 256) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    return w + 1 + (halt_get ? 1 : 0) + 2 * nbytes + (steal ? 2 : 0);
  endfunction

  // Lone DMC fetch from IDLE: HALT, DUMMY, optional ALIGN, DMC_RD.
  function automatic int gen_dmc(logic [7:0] din);
    bit sp;
    int n;
    sp = g_put;
    gcpu(1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    if (DmcEn) begin
      gcpu(1'b0, 1'b0, 1'b1, 1'b0);
      gcpu(1'b0, 1'b0, 1'b1, 1'b0);
      if (g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b0);
      gdmc_rd(din);
      n = sp ? 3 : 4;
    end
    gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    return n;
  endfunction

  task automatic run_q(output int lows);
    lows = 0;
    foreach (q[i]) begin
      cpu_addr  = q[i].ca;
      cpu_rw    = q[i].crw;
      oam_start = q[i].os;
      oam_page  = q[i].pg;
      dmc_req   = q[i].dr;
      dmc_addr  = q[i].da;
      db_in     = q[i].din;
      #1;
      if (RDY === 1'b0) lows++;
      total++;
      if (Addr_topad !== q[i].ea || RW_topad !== q[i].erw || db_oe !== q[i].eoe ||
          (q[i].eoe && db_out !== q[i].edo) || RDY !== q[i].erdy ||
          dmc_ack !== q[i].eack || dmc_data !== q[i].edat || dma_busy !== !q[i].erdy) begin
        bad++;
        $display("FAIL %s cyc%0d: got addr=%h rw=%b oe=%b dout=%h rdy=%b ack=%b data=%h busy=%b; want addr=%h rw=%b oe=%b dout=%h rdy=%b ack=%b data=%h busy=%b",
                 g_name, i, Addr_topad, RW_topad, db_oe, db_out, RDY, dmc_ack, dmc_data,
                 dma_busy, q[i].ea, q[i].erw, q[i].eoe, q[i].edo, q[i].erdy, q[i].eack,
                 q[i].edat, !q[i].erdy);
      end
      @(negedge CLK);
    end
    q.delete();
  endtask

  task automatic scen(string nm, int low_exp);
    int lows;
    g_name = nm;
    run_q(lows);
    total++;
    if (lows != low_exp) begin
      bad++;
      $display("FAIL %s rdy_low_cycles: got %0d want %0d", nm, lows, low_exp);
    end
  endtask

  task automatic chk_reset(string nm);
    total++;
    if (Addr_topad !== cpu_addr || RW_topad !== cpu_rw || db_oe !== 1'b0 || db_out !== 8'h00 ||
        RDY !== 1'b1 || dmc_ack !== 1'b0 || dmc_data !== 8'h00 || dma_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s: got addr=%h rw=%b oe=%b dout=%h rdy=%b ack=%b data=%h busy=%b; want addr=%h rw=%b oe=0 dout=00 rdy=1 ack=0 data=00 busy=0",
               nm, Addr_topad, RW_topad, db_oe, db_out, RDY, dmc_ack, dmc_data, dma_busy,
               cpu_addr, cpu_rw);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int le;
    int at;
    n_RES     = 1'b0;
    cpu_addr  = 16'h1234;
    cpu_rw    = 1'b1;
    oam_start = 1'b0;
    oam_page  = 8'h00;
    dmc_req   = 1'b0;
    dmc_addr  = 16'h0000;
    db_in     = 8'hA5;
    total     = 0;
    bad       = 0;
    g_put     = 1'b0;
    g_ack     = 1'b0;
    g_ack_dat = 8'h00;
    g_dat     = 8'h00;
    g_page    = 8'h00;
    g_daddr   = 16'hC000;

    @(negedge CLK);
    chk_reset("reset_first");
    cpu_addr = 16'hBEEF;
    cpu_rw   = 1'b0;
    @(negedge CLK);
    chk_reset("reset_hold");
    n_RES = 1'b1;

    repeat (6) gcpu(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    scen("idle", 0);

    // $4014 written on a put-cycle, so HALT lands on a get-cycle and ALIGN follows.
    if (!g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_page = 8'h02;
    le = gen_oam(0, 1'b0, -1, 256);
    scen("oam_p02", le);

    gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_page = 8'($urandom);
    le = gen_oam(3, 1'b0, -1, 256);
    scen("oam_3wr", le);

    g_daddr = 16'hC000;
    if (g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    le = gen_dmc(8'h5A);
    scen("dmc_get_start", le);
    if (!g_put) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_daddr = 16'hC123;
    le = gen_dmc(8'hC3);
    scen("dmc_put_start", le);

`ifndef APU_DMC_DMA_EN
    repeat (20) gcpu(1'b0, 1'b1, 1'b1, 1'b1);
    scen("dmc_held_ignored", 0);
`endif

    gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_page  = 8'h45;
    g_daddr = 16'hE010;
    le = gen_oam(0, 1'b0, 16, 256);
    scen("oam_dmc16", le);

    gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_page  = 8'h07;
    g_daddr = 16'hD800;
    le = gen_oam(1, 1'b1, -1, 256);
    scen("oam_dmc_start", le);

    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 3)) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
      g_page  = 8'($urandom);
      g_daddr = 16'($urandom);
      at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 254)) : -1;
      le = gen_oam(int'($urandom_range(0, 3)), 1'b0, at, 256);
      scen("oam_rand", le);
    end

    // Reset asserted in the middle of the copy, just as cnt reaches 100.
    gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    g_page = 8'h3C;
    le = gen_oam(0, 1'b0, -1, 100);
    scen("oam_pre_reset", le);
    cpu_addr  = 16'h8123;
    cpu_rw    = 1'b1;
    oam_start = 1'b0;
    dmc_req   = 1'b0;
    #2;
    n_RES = 1'b0;
    #1;
    chk_reset("reset_mid_async");
    @(posedge CLK);
    #1;
    chk_reset("reset_mid_hold");
    @(negedge CLK);
    n_RES = 1'b1;
    g_put = 1'b0;
    g_ack = 1'b0;
    g_dat = 8'h00;

    g_page = 8'h7E;
    le = gen_oam(0, 1'b0, -1, 256);
    scen("oam_after_reset", le);

    repeat (3) gcpu(1'b0, 1'b0, 1'b1, 1'b1);
    scen("idle_end", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
